// File: rtl/keypad_set_ctrl.sv
// Purpose : keypad/button sequencer for the alarm clock; gathers four BCD digits (HH:MM),
//           validates them and issues one-cycle load strobes to the time counter or alarm register.
// Latency : key digits visible one edge after the key press edge; strobes registered, one clk wide,
//           starting at the edge that detects the button rising edge; entry clears one edge later.
// Backpr. : none; inputs are level signals sampled every clock, events during a strobe are dropped.
//
// Ports
//   clk            system clock, all state changes on posedge
//   reset          asynchronous active-low reset
//   keypad_buttons one bit per digit key (bit n = digit n), level while held
//   time_button    rising edge commits the entry as the current time
//   alarm_button   rising edge commits the entry as the alarm; level in IDLE shows the alarm
//   entry_digits   BCD {h_tens,h_ones,m_tens,m_ones} being entered
//   load_time      one-cycle strobe: time counter loads entry_digits
//   load_alarm     one-cycle strobe: alarm register loads entry_digits
//   entry_err      one-cycle strobe: commit rejected (incomplete or out-of-range)
//   disp_sel       00 = current time, 01 = alarm, 10 = entry_digits
module keypad_set_ctrl #(
   parameter int TIMEOUT_CYCLES = 153600,
   parameter int TO_W           = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  keypad_buttons,
   input  logic        time_button,
   input  logic        alarm_button,
   output logic [15:0] entry_digits,
   output logic        load_time,
   output logic        load_alarm,
   output logic        entry_err,
   output logic [1:0]  disp_sel
);

   typedef enum logic {IDLE = 1'b0, ENTRY = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [9:0]      keys_prev;
   logic            time_prev, alarm_prev;
   logic [2:0]      count, count_nxt;
   logic [15:0]     digits_nxt;
   logic [TO_W-1:0] to_cnt, to_nxt;
   logic            load_time_nxt, load_alarm_nxt, entry_err_nxt;

   logic            one_hot, key_evt, time_evt, alarm_evt, btn_evt;
   logic [3:0]      key_digit;
   logic            entry_ok, strobe_pend, to_done;

   // A key event needs exactly one key down after a cycle with no key down,
   // so held keys and chords never produce more than one digit.
   assign one_hot   = (keypad_buttons != 10'd0) &&
                      ((keypad_buttons & (keypad_buttons - 10'd1)) == 10'd0);
   assign key_evt   = one_hot && (keys_prev == 10'd0);
   assign time_evt  = time_button  & ~time_prev;
   assign alarm_evt = alarm_button & ~alarm_prev;
   assign btn_evt   = time_evt | alarm_evt;

   always_comb begin
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keypad_buttons[i]) key_digit = 4'(i);
      end
   end

   // Hours 00..23 and minute tens 0..5; BCD digits themselves never exceed 9.
   assign entry_ok = ((entry_digits[15:12] < 4'd2) ||
                      (entry_digits[15:12] == 4'd2 && entry_digits[11:8] <= 4'd3)) &&
                     (entry_digits[7:4] <= 4'd5);

   // A strobe in flight means the committed value is on entry_digits this cycle
   // and must be cleared at the next edge.
   assign strobe_pend = load_time | load_alarm | entry_err;
   assign to_done     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nxt      = state;
      digits_nxt     = entry_digits;
      count_nxt      = count;
      to_nxt         = to_cnt;
      load_time_nxt  = 1'b0;
      load_alarm_nxt = 1'b0;
      entry_err_nxt  = 1'b0;
      case (state)
         IDLE: begin
            to_nxt = '0;
            if (key_evt) begin
               digits_nxt = {entry_digits[11:0], key_digit};
               count_nxt  = 3'd1;
               state_nxt  = ENTRY;
            end
         end
         ENTRY: begin
            if (strobe_pend) begin
               digits_nxt = 16'd0;
               count_nxt  = 3'd0;
               to_nxt     = '0;
               state_nxt  = IDLE;
            end else if (btn_evt) begin
               // Digits are held so the load target sees them during the strobe;
               // a key arriving in this same cycle is deliberately dropped.
               if (count == 3'd4 && entry_ok) begin
                  if (time_evt) load_time_nxt  = 1'b1;
                  else          load_alarm_nxt = 1'b1;
               end else begin
                  entry_err_nxt = 1'b1;
               end
            end else if (key_evt) begin
               digits_nxt = {entry_digits[11:0], key_digit};
               count_nxt  = (count == 3'd4) ? 3'd4 : count + 3'd1;
               to_nxt     = '0;
            end else if (to_done) begin
               digits_nxt = 16'd0;
               count_nxt  = 3'd0;
               to_nxt     = '0;
               state_nxt  = IDLE;
            end else begin
               to_nxt = to_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         keys_prev    <= 10'd0;
         time_prev    <= 1'b0;
         alarm_prev   <= 1'b0;
         entry_digits <= 16'd0;
         count        <= 3'd0;
         to_cnt       <= '0;
         load_time    <= 1'b0;
         load_alarm   <= 1'b0;
         entry_err    <= 1'b0;
      end else begin
         state        <= state_nxt;
         keys_prev    <= keypad_buttons;
         time_prev    <= time_button;
         alarm_prev   <= alarm_button;
         entry_digits <= digits_nxt;
         count        <= count_nxt;
         to_cnt       <= to_nxt;
         load_time    <= load_time_nxt;
         load_alarm   <= load_alarm_nxt;
         entry_err    <= entry_err_nxt;
      end
   end

   always_comb begin
      if (state == ENTRY)    disp_sel = 2'b10;
      else if (alarm_button) disp_sel = 2'b01;
      else                   disp_sel = 2'b00;
   end

endmodule

// File: tb/tb_keypad_set_ctrl.sv
module tb_keypad_set_ctrl;

   localparam int T = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  keypad_buttons = 10'd0;
   logic        time_button = 1'b0;
   logic        alarm_button = 1'b0;
   logic [15:0] entry_digits;
   logic        load_time, load_alarm, entry_err;
   logic [1:0]  disp_sel;

   keypad_set_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
      .clk(clk), .reset(reset), .keypad_buttons(keypad_buttons),
      .time_button(time_button), .alarm_button(alarm_button),
      .entry_digits(entry_digits), .load_time(load_time), .load_alarm(load_alarm),
      .entry_err(entry_err), .disp_sel(disp_sel)
   );

   always #5 clk = ~clk;

   // Expected strobe: kind 0 = load_time, 1 = load_alarm, 2 = entry_err.
   typedef struct {
      int          kind;
      logic [15:0] val;
   } exp_t;

   exp_t expq[$];
   int   ent[$];        // digits keyed since the entry began
   bit   m_entry = 0;   // reference model: an entry is in progress
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Entry display = last four keys, leading zeros if fewer were typed.
   function automatic logic [15:0] mval();
      logic [15:0] v = 16'd0;
      foreach (ent[i]) v = {v[11:0], 4'(ent[i])};
      return v;
   endfunction

   task automatic key(input int d, input int on, input int off);
      @(negedge clk);
      keypad_buttons = 10'(1) << d;
      if (!m_entry) begin
         m_entry = 1;
         ent.delete();
      end
      ent.push_back(d);
      repeat (on) @(negedge clk);
      keypad_buttons = 10'd0;
      repeat (off) @(negedge clk);
      chk("entry_digits", 32'(entry_digits), 32'(mval()));
      chk("disp_entry", 32'(disp_sel), 32'd2);
   endtask

   task automatic btn(input bit t, input bit a);
      exp_t e;
      int   n, hh, mt;
      @(negedge clk);
      time_button  = t;
      alarm_button = a;
      if (m_entry) begin
         n = ent.size();
         e.val = mval();
         if (n < 4) begin
            e.kind = 2;
         end else begin
            hh = ent[n-4] * 10 + ent[n-3];
            mt = ent[n-2];
            if (hh <= 23 && mt <= 5) e.kind = t ? 0 : 1;
            else                     e.kind = 2;
         end
         expq.push_back(e);
         m_entry = 0;
      end
      repeat (2) @(negedge clk);
      time_button  = 1'b0;
      alarm_button = 1'b0;
      repeat (3) @(negedge clk);
      chk("after_commit_digits", 32'(entry_digits), 32'd0);
      chk("after_commit_disp", 32'(disp_sel), 32'd0);
   endtask

   // Monitor: every strobe cycle pops one expectation.
   bit post = 0;
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      if (post) begin
         post = 0;
         chk("post_strobe_digits", 32'(entry_digits), 32'd0);
         chk("post_strobe_disp_hi", 32'(disp_sel[1]), 32'd0);
      end
      if (load_time | load_alarm | entry_err) begin
         chk("strobe_onehot", 32'(load_time) + 32'(load_alarm) + 32'(entry_err), 32'd1);
         kind = load_time ? 0 : (load_alarm ? 1 : 2);
         if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got kind %0d digits %h expected none at %0t",
                     kind, entry_digits, $time);
         end else begin
            e = expq.pop_front();
            chk("strobe_kind", 32'(kind), 32'(e.kind));
            chk("strobe_digits", 32'(entry_digits), 32'(e.val));
         end
         post = 1;
      end
   end

   int dg[6];
   int bad;

   initial begin
      // Reset state
      #1;
      chk("reset_digits", 32'(entry_digits), 32'd0);
      chk("reset_strobes", {29'd0, load_time, load_alarm, entry_err}, 32'd0);
      chk("reset_disp", 32'(disp_sel), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Reset in the middle of an entry
      key(3, 2, 2);
      key(7, 2, 2);
      @(negedge clk);
      reset = 1'b0;
      m_entry = 0;
      #1;
      chk("midreset_digits", 32'(entry_digits), 32'd0);
      chk("midreset_disp", 32'(disp_sel), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      btn(1, 0);

      // Basic time load 04:35
      key(0, 10, 10); key(4, 10, 10); key(3, 10, 10); key(5, 10, 10);
      btn(1, 0);

      // Alarm display while held in IDLE, no strobes
      @(negedge clk);
      alarm_button = 1'b1;
      bad = 0;
      repeat (T + 1) begin
         @(negedge clk);
         if (disp_sel !== 2'b01) bad++;
      end
      chk("alarm_hold_disp_bad_cycles", 32'(bad), 32'd0);
      alarm_button = 1'b0;
      @(negedge clk);
      chk("alarm_release_disp", 32'(disp_sel), 32'd0);

      // Out-of-range hours, then incomplete entry
      key(2, 2, 2); key(5, 2, 2); key(0, 2, 2); key(0, 2, 2);
      btn(0, 1);
      key(1, 2, 2); key(7, 2, 2);
      btn(1, 0);

      // Six keys keep the last four; chord ignored; long hold counts once
      key(1, 2, 2); key(2, 2, 2); key(3, 50, 2);
      @(negedge clk);
      keypad_buttons = 10'h011;
      repeat (3) @(negedge clk);
      keypad_buttons = 10'd0;
      repeat (2) @(negedge clk);
      chk("multihot_ignored", 32'(entry_digits), 32'(mval()));
      key(4, 2, 2); key(0, 2, 2); key(7, 2, 2);
      btn(0, 1);
      key(9, 2, 2); key(1, 2, 2); key(2, 2, 2); key(3, 2, 2); key(0, 2, 2); key(7, 2, 2);
      btn(0, 1);

      // Timeout abandons the entry silently
      key(1, 2, 2); key(2, 2, 2);
      repeat (T - 10) @(negedge clk);
      chk("before_timeout_disp", 32'(disp_sel), 32'd2);
      repeat (15) @(negedge clk);
      m_entry = 0;
      chk("timeout_digits", 32'(entry_digits), 32'd0);
      chk("timeout_disp", 32'(disp_sel), 32'd0);
      btn(1, 0);

      // Simultaneous edges: time wins
      key(0, 2, 2); key(9, 2, 2); key(3, 2, 2); key(0, 2, 2);
      btn(1, 1);

      // Randomized entries
      for (int it = 0; it < 40; it++) begin
         int nk, hh;
         nk = $urandom_range(0, 6);
         for (int j = 0; j < 6; j++) dg[j] = $urandom_range(0, 9);
         if (nk >= 4 && $urandom_range(0, 1) == 1) begin
            hh = $urandom_range(0, 25);
            dg[nk-4] = hh / 10;
            dg[nk-3] = hh % 10;
            dg[nk-2] = $urandom_range(0, 6);
         end
         for (int j = 0; j < nk; j++)
            key(dg[j], $urandom_range(1, 4), $urandom_range(1, 4));
         case ($urandom_range(0, 2))
            0:       btn(1, 0);
            1:       btn(0, 1);
            default: btn(1, 1);
         endcase
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
